// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with Mealy and Moore outputs
// driven from one shared prefix-tracking state machine.
//
// Ports:
//   clk        rising-edge system clock
//   rst        synchronous active-high reset (priority over en/clr_cnt)
//   en         qualifies j; state holds when low
//   j          serial data bit, PATTERN[PAT_W-1] received first
//   clr_cnt    synchronous clear of match_cnt and cnt_sat
//   mealy_out  combinational match on the completing bit
//   moore_out  registered match, one cycle after mealy_out
//   match_cnt  saturating count of matches
//   cnt_sat    sticky flag, set once match_cnt reaches all-ones
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             j,
    input  logic             clr_cnt,
    output logic             mealy_out,
    output logic             moore_out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int SW = $clog2(PAT_W + 1);
    localparam int NS = 1 << SW;
    localparam logic [SW-1:0] S_FULL = SW'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Longest pattern prefix that is a suffix of (matched prefix, b).
    // A full match restarts from an empty prefix when overlap is off.
    function automatic int nxt_f(input int s, input logic b);
        int sp;
        int len;
        int best;
        logic ok;
        logic [PAT_W:0] seq;
        sp = (s == PAT_W && !OVERLAP) ? 0 : s;
        len = sp + 1;
        seq = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < sp) seq[i] = PATTERN[PAT_W-1-i];
        end
        seq[sp] = b;
        best = 0;
        for (int k = 1; k <= PAT_W; k++) begin
            if (k <= len) begin
                ok = 1'b1;
                for (int m = 0; m < k; m++) begin
                    if (PATTERN[PAT_W-1-m] != seq[len-k+m]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    logic [SW-1:0] tbl0 [NS];
    logic [SW-1:0] tbl1 [NS];

    // Encodings above PAT_W are unreachable; they fall back to 0.
    for (genvar g = 0; g < NS; g++) begin : g_tbl
        if (g <= PAT_W) begin : g_v
            localparam int N0 = nxt_f(g, 1'b0);
            localparam int N1 = nxt_f(g, 1'b1);
            assign tbl0[g] = SW'(N0);
            assign tbl1[g] = SW'(N1);
        end else begin : g_u
            assign tbl0[g] = '0;
            assign tbl1[g] = '0;
        end
    end

    logic [SW-1:0] s;
    logic [SW-1:0] s_adv;
    logic [SW-1:0] s_next;

    always_ff @(posedge clk) begin
        if (rst) s <= '0;
        else     s <= s_next;
    end

    always_comb begin
        s_adv  = j ? tbl1[s] : tbl0[s];
        s_next = s;
        if (en) s_next = s_adv;
    end

    assign mealy_out = en & (s_adv == S_FULL);
    assign moore_out = (s == S_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (clr_cnt) begin
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (mealy_out && match_cnt != CNT_MAX) begin
            match_cnt <= match_cnt + 1'b1;
            if (match_cnt == CNT_MAX - 1'b1) cnt_sat <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: four parameter sets share one stream
// and are checked against a bit-history reference model.
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic j = 1'b0;
    logic clr_cnt = 1'b0;

    logic [3:0] mealy_v;
    logic [3:0] moore_v;
    logic [3:0] sat_v;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] c2;
    logic [1:0] c3;

    always #5 clk = ~clk;

    seq_detector_param u_d0 (
        .clk(clk), .rst(rst), .en(en), .j(j), .clr_cnt(clr_cnt),
        .mealy_out(mealy_v[0]), .moore_out(moore_v[0]),
        .match_cnt(c0), .cnt_sat(sat_v[0])
    );

    seq_detector_param #(.OVERLAP(1'b0)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .j(j), .clr_cnt(clr_cnt),
        .mealy_out(mealy_v[1]), .moore_out(moore_v[1]),
        .match_cnt(c1), .cnt_sat(sat_v[1])
    );

    seq_detector_param #(.PAT_W(2), .PATTERN(2'b11)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .j(j), .clr_cnt(clr_cnt),
        .mealy_out(mealy_v[2]), .moore_out(moore_v[2]),
        .match_cnt(c2), .cnt_sat(sat_v[2])
    );

    seq_detector_param #(.CNT_W(2)) u_d3 (
        .clk(clk), .rst(rst), .en(en), .j(j), .clr_cnt(clr_cnt),
        .mealy_out(mealy_v[3]), .moore_out(moore_v[3]),
        .match_cnt(c3), .cnt_sat(sat_v[3])
    );

    typedef struct packed {
        logic [3:0]      mealy;
        logic [3:0]      moore;
        logic [3:0]      sat;
        logic [3:0][7:0] cnt;
    } exp_t;

    exp_t sb[$];

    int pw[4]   = '{4, 4, 2, 4};
    int pat[4]  = '{9, 9, 3, 9};
    bit ovl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    int cmax[4] = '{255, 255, 255, 3};

    logic [31:0] hist[4];
    int  hlen[4];
    bit  mmoore[4];
    int  mcnt[4];
    bit  msat[4];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int cnt_of(input int d);
        case (d)
            0: return int'(c0);
            1: return int'(c1);
            2: return int'(c2);
            default: return int'(c3);
        endcase
    endfunction

    task automatic drive(input bit r, input bit e, input bit b, input bit c);
        exp_t x;
        logic [31:0] h2;
        logic [31:0] mask;
        bit m;
        @(negedge clk);
        rst = r;
        en = e;
        j = b;
        clr_cnt = c;
        x = '0;
        for (int d = 0; d < 4; d++) begin
            h2 = {hist[d][30:0], b};
            mask = (32'd1 << pw[d]) - 32'd1;
            m = !r && e && (hlen[d] + 1 >= pw[d]) &&
                ((h2 & mask) == 32'(pat[d]));
            x.mealy[d] = m;
            if (r) begin
                hist[d] = '0;
                hlen[d] = 0;
                mmoore[d] = 1'b0;
                mcnt[d] = 0;
                msat[d] = 1'b0;
            end else begin
                if (e) begin
                    mmoore[d] = m;
                    if (m && !ovl[d]) begin
                        hist[d] = '0;
                        hlen[d] = 0;
                    end else begin
                        hist[d] = h2;
                        hlen[d] = (hlen[d] < 32) ? hlen[d] + 1 : 32;
                    end
                end
                if (c) begin
                    mcnt[d] = 0;
                    msat[d] = 1'b0;
                end else if (m && mcnt[d] != cmax[d]) begin
                    mcnt[d]++;
                    if (mcnt[d] == cmax[d]) msat[d] = 1'b1;
                end
            end
            x.moore[d] = mmoore[d];
            x.sat[d] = msat[d];
            x.cnt[d] = 8'(mcnt[d]);
        end
        sb.push_back(x);
        #1;
        x = sb[0];
        for (int d = 0; d < 4; d++)
            chk($sformatf("d%0d_mealy", d), int'(mealy_v[d]), int'(x.mealy[d]));
        @(posedge clk);
        #1;
        x = sb.pop_front();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("d%0d_moore", d), int'(moore_v[d]), int'(x.moore[d]));
            chk($sformatf("d%0d_cnt", d), cnt_of(d), int'(x.cnt[d]));
            chk($sformatf("d%0d_sat", d), int'(sat_v[d]), int'(x.sat[d]));
        end
    endtask

    task automatic do_rst();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b1, v[i], 1'b0);
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            hist[d] = '0;
            hlen[d] = 0;
            mmoore[d] = 1'b0;
            mcnt[d] = 0;
            msat[d] = 1'b0;
        end

        do_rst();
        chk("rst_moore", int'(moore_v), 0);
        chk("rst_cnt0", cnt_of(0), 0);
        chk("rst_sat", int'(sat_v), 0);

        bits(16'b1001001, 7);
        chk("t1_cnt_ovl", cnt_of(0), 2);
        chk("t2_cnt_novl", cnt_of(1), 1);
        chk("t1_cnt_p11", cnt_of(2), 0);

        do_rst();
        bits(16'b100, 3);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_gap_moore", int'(moore_v[0]), 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_cnt", cnt_of(0), 1);
        chk("t3_moore", int'(moore_v[0]), 1);

        do_rst();
        bits(16'b1111, 4);
        chk("t4_cnt_p11", cnt_of(2), 3);
        chk("t4_moore_p11", int'(moore_v[2]), 1);

        do_rst();
        bits(16'b100, 3);
        do_rst();
        bits(16'b1001, 4);
        chk("t5_cnt", cnt_of(0), 1);

        do_rst();
        bits(16'b1001001001001001, 16);
        chk("t6_cnt_sat", cnt_of(3), 3);
        chk("t6_sat_flag", int'(sat_v[3]), 1);
        chk("t6_cnt_wide", cnt_of(0), 5);
        bits(16'b00, 2);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        chk("t6_clr_cnt", cnt_of(3), 0);
        chk("t6_clr_sat", int'(sat_v[3]), 0);
        chk("t6_clr_moore", int'(moore_v[3]), 1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0)
                drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            else
                drive(1'b0, 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial-bit pattern detector. It provides a Mealy output and a Moore output from a single shared prefix-tracking state machine, so both detection styles are always consistent with each other. It adds several features over single-pattern detectors: a compile-time pattern and width, an overlap/non-overlap mode, an input-enable qualifier, and a saturating match counter. It sits directly on a 1-bit serial stream and feeds downstream logic or a bench comparator.

Parameters:
PAT_W, 4, pattern length in bits (2..16).
PATTERN, 4'b1001, target sequence. PATTERN[PAT_W-1] is the first bit received.
OVERLAP, 1, 1 = matches may share bits; 0 = search restarts after each match.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  j is sampled only in cycles where en=1.
j  input  1  serial data bit.
clr_cnt  input  1  synchronous clear of match_cnt and cnt_sat.
mealy_out  output  1  combinational; high in the cycle where the completing bit is presented.
moore_out  output  1  registered; high for the cycle after the completing bit is sampled.
match_cnt  output  CNT_W  number of matches detected, saturating.
cnt_sat  output  1  sticky flag; set when match_cnt reaches all-ones.

Behaviour:
- State s = number of leading PATTERN bits currently matched, range 0..PAT_W. Encoding: ceil(log2(PAT_W+1)) bits.
- Reset (rst=1 at a clock edge): s=0, match_cnt=0, cnt_sat=0. This gives moore_out=0. mealy_out is 0 whenever s=0 and the current bit cannot complete the pattern. rst has priority over en and clr_cnt.
- Transition nxt(s,b): the largest k <= PAT_W such that PATTERN[PAT_W-1 -: k] equals the last k bits of (the matched prefix of length s') followed by b. Here s' is defined as:
  - s' = s when s < PAT_W;
  - s' = s when s = PAT_W and OVERLAP=1 (KMP failure behaviour);
  - s' = 0 when s = PAT_W and OVERLAP=0.
- The transition table is computed at elaboration time by a function or generate loop; a hand-coded table is not acceptable.
- en=1: s <= nxt(s,j). en=0: s holds, so moore_out holds its value.
- mealy_out = en & (nxt(s,j) == PAT_W). It is purely combinational with zero latency and may glitch while j settles.
- moore_out = (s == PAT_W). It goes high exactly one cycle after the mealy_out pulse for the same match.
- Counter behaviour:
  - On each edge where en=1, mealy_out=1 and clr_cnt=0, match_cnt increments.
  - At all-ones, match_cnt holds and cnt_sat stays 1 until clr_cnt or rst.
  - clr_cnt=1: match_cnt <= 0 and cnt_sat <= 0. A match in the same cycle is dropped (clear wins).
  - The state machine is unaffected by clr_cnt.
- Reset mid-sequence: any partial match is discarded, and the next bit is evaluated from s=0.
- All-same-bit patterns (e.g. 4'b1111 with OVERLAP=1): from s=PAT_W, a matching bit yields s=PAT_W again. moore_out stays high continuously and the counter increments every qualified bit.
- There are no latches. Every output is defined every cycle after the first reset.

Test Plan:
1. Default params, rst for 1 cycle, then en=1 and j stream 1,0,0,1,0,0,1 -> mealy_out high on bits 4 and 7; moore_out high the cycles after bits 4 and 7; match_cnt=2.
2. OVERLAP=0, same stream -> a single match at bit 4; bits 5..7 give no match; match_cnt=1, moore_out high only once.
3. Default params, stream 1,0,0 with en held 0 for 3 cycles, then en=1 with j=1 -> s holds at 3 during the gap, match on the resumed bit, match_cnt=1. Bits presented while en=0 are ignored.
4. PATTERN=2'b11, PAT_W=2, OVERLAP=1, stream 1,1,1,1 -> mealy_out high on bits 2,3,4; moore_out high for 3 consecutive cycles; match_cnt=3.
5. Default params, rst asserted after 1,0,0, then stream 1,0,0,1 -> the first 1 after reset does not complete a match; a match occurs only on the final bit; match_cnt=1.
6. CNT_W=2, five matches -> match_cnt saturates at 3 with cnt_sat=1. Then clr_cnt coinciding with a match -> match_cnt=0 and cnt_sat=0 the next cycle, and the state machine still reaches s=PAT_W.
